// File: rtl/multi_id_generator_core.sv
// multi_id_generator_core
//   Walks a PE_ARRAY_H x PE_ARRAY_W processing-element array in row-major
//   order. Each scan cycle it registers the multicast X/Y tags of one PE.
//   These are the filter, ifmap, input-psum and output-psum tags, produced
//   by either the convolution mapping or the fully-connected mapping.
//
//   State table
//   state | meaning
//   IDLE  | after reset; outputs hold, no counting
//   SCAN  | one PE per cycle: register its IDs, then advance col/row
//   DONE  | full array visited; last IDs and both flags held until start
//
// Ports
//   clk, rst_n             rising-edge clock, synchronous active-low reset
//   start                  one-cycle pulse that (re)starts a scan
//   PE_ARRAY_H/W           array rows / columns
//   KERNEL_H, e            PE-set height (filter rows) and width (ofmap rows)
//   t_H, t_W               PE sets stacked vertically / horizontally
//   p, q, r, t             reserved, ignored in this revision
//   LINEAR                 1 = fully-connected mapping
//   *_XID / *_YID          registered tags of the current PE
//   x_done                 whole array scanned
//   y_done                 scan has reached the last row
module multi_id_generator_core (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [2:0] PE_ARRAY_H,
   input  logic [3:0] PE_ARRAY_W,
   input  logic [1:0] KERNEL_H,
   input  logic [2:0] p,
   input  logic [2:0] q,
   input  logic [2:0] r,
   input  logic [2:0] t,
   input  logic [2:0] t_H,
   input  logic [2:0] t_W,
   input  logic [2:0] e,
   input  logic       LINEAR,
   output logic [4:0] filter_XID,
   output logic [2:0] filter_YID,
   output logic [4:0] ifmap_XID,
   output logic [2:0] ifmap_YID,
   output logic [4:0] ipsum_XID,
   output logic [2:0] ipsum_YID,
   output logic [4:0] opsum_XID,
   output logic [2:0] opsum_YID,
   output logic       x_done,
   output logic       y_done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] row_cnt_XID_q, row_cnt_XID_d;
   logic [3:0] col_cnt_XID_q, col_cnt_XID_d;
   logic [4:0] filter_x_q, filter_x_d;
   logic [2:0] filter_y_q, filter_y_d;
   logic [4:0] ifmap_x_q, ifmap_x_d;
   logic [2:0] ifmap_y_q, ifmap_y_d;
   logic [4:0] ipsum_x_q, ipsum_x_d;
   logic [2:0] ipsum_y_q, ipsum_y_d;
   logic [4:0] opsum_x_q, opsum_x_d;
   logic [2:0] opsum_y_q, opsum_y_d;
   logic       x_done_q, x_done_d;
   logic       y_done_q, y_done_d;

   // Reserved mapping parameters are collected here so they are visibly unused.
   logic       cfg_unused;
   assign cfg_unused = ^{p, q, r, t};

   // ID arithmetic for the PE currently addressed by the counters, 8-bit wide.
   logic [7:0] i8, j8, kh8, e8, kh_div, e_div;
   logic [7:0] sv, ri, sh, cj, span, ifx;
   logic       pe_active;
   logic [4:0] pe_filter_x, pe_ifmap_x, pe_ipsum_x, pe_opsum_x;
   logic [2:0] pe_filter_y, pe_ifmap_y, pe_ipsum_y, pe_opsum_y;
   logic [2:0] ifx_unused_bits;

   always_comb begin
      i8   = {5'd0, row_cnt_XID_q};
      j8   = {4'd0, col_cnt_XID_q};
      kh8  = {6'd0, KERNEL_H};
      e8   = {5'd0, e};
      // A zero divisor only occurs when the PE is forced inactive anyway;
      // substituting 1 keeps the dividers well defined.
      kh_div = (KERNEL_H == 2'd0) ? 8'd1 : kh8;
      e_div  = (e == 3'd0)        ? 8'd1 : e8;
      sv   = i8 / kh_div;
      ri   = i8 % kh_div;
      sh   = j8 / e_div;
      cj   = j8 % e_div;
      span = kh8 + e8 - 8'd1;
      ifx  = ri + cj + sh * span;
      ifx_unused_bits = ifx[7:5];

      pe_active = (sv < {5'd0, t_H}) && (sh < {5'd0, t_W}) &&
                  (KERNEL_H != 2'd0) && (e != 3'd0);

      pe_filter_x = 5'h1F;
      pe_filter_y = 3'h7;
      pe_ifmap_x  = 5'h1F;
      pe_ifmap_y  = 3'h7;
      pe_ipsum_x  = 5'h1F;
      pe_ipsum_y  = 3'h7;
      pe_opsum_x  = 5'h1F;
      pe_opsum_y  = 3'h7;

      if (LINEAR) begin
         pe_filter_x = {1'b0, col_cnt_XID_q};
         pe_filter_y = row_cnt_XID_q;
         pe_ifmap_x  = 5'd0;
         pe_ifmap_y  = row_cnt_XID_q;
         pe_ipsum_x  = {1'b0, col_cnt_XID_q};
         pe_ipsum_y  = row_cnt_XID_q;
         pe_opsum_x  = {1'b0, col_cnt_XID_q};
         pe_opsum_y  = row_cnt_XID_q;
      end else if (pe_active) begin
         pe_filter_x = sh[4:0];
         pe_filter_y = row_cnt_XID_q;
         pe_ifmap_x  = ifx[4:0];
         pe_ifmap_y  = sv[2:0];
         pe_ipsum_x  = {1'b0, col_cnt_XID_q};
         pe_ipsum_y  = sv[2:0];
         pe_opsum_x  = {1'b0, col_cnt_XID_q};
         pe_opsum_y  = sv[2:0];
      end
   end

   logic last_col, last_row;
   assign last_col = (col_cnt_XID_q == PE_ARRAY_W - 4'd1);
   assign last_row = (row_cnt_XID_q == PE_ARRAY_H - 3'd1);

   always_comb begin
      state_d       = state_q;
      row_cnt_XID_d = row_cnt_XID_q;
      col_cnt_XID_d = col_cnt_XID_q;
      filter_x_d    = filter_x_q;
      filter_y_d    = filter_y_q;
      ifmap_x_d     = ifmap_x_q;
      ifmap_y_d     = ifmap_y_q;
      ipsum_x_d     = ipsum_x_q;
      ipsum_y_d     = ipsum_y_q;
      opsum_x_d     = opsum_x_q;
      opsum_y_d     = opsum_y_q;
      x_done_d      = x_done_q;
      y_done_d      = y_done_q;

      if (start) begin
         row_cnt_XID_d = 3'd0;
         col_cnt_XID_d = 4'd0;
         if (PE_ARRAY_H == 3'd0 || PE_ARRAY_W == 4'd0) begin
            // Empty array: nothing to scan, report completion immediately.
            state_d  = DONE;
            x_done_d = 1'b1;
            y_done_d = 1'b1;
         end else begin
            state_d  = SCAN;
            x_done_d = 1'b0;
            y_done_d = 1'b0;
         end
      end else begin
         case (state_q)
            SCAN: begin
               filter_x_d = pe_filter_x;
               filter_y_d = pe_filter_y;
               ifmap_x_d  = pe_ifmap_x;
               ifmap_y_d  = pe_ifmap_y;
               ipsum_x_d  = pe_ipsum_x;
               ipsum_y_d  = pe_ipsum_y;
               opsum_x_d  = pe_opsum_x;
               opsum_y_d  = pe_opsum_y;
               if (last_row && col_cnt_XID_q == 4'd0) y_done_d = 1'b1;
               if (last_col) begin
                  col_cnt_XID_d = 4'd0;
                  if (last_row) begin
                     x_done_d = 1'b1;
                     state_d  = DONE;
                  end else begin
                     row_cnt_XID_d = row_cnt_XID_q + 3'd1;
                  end
               end else begin
                  col_cnt_XID_d = col_cnt_XID_q + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         row_cnt_XID_q <= 3'd0;
         col_cnt_XID_q <= 4'd0;
         filter_x_q    <= 5'd0;
         filter_y_q    <= 3'd0;
         ifmap_x_q     <= 5'd0;
         ifmap_y_q     <= 3'd0;
         ipsum_x_q     <= 5'd0;
         ipsum_y_q     <= 3'd0;
         opsum_x_q     <= 5'd0;
         opsum_y_q     <= 3'd0;
         x_done_q      <= 1'b0;
         y_done_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         row_cnt_XID_q <= row_cnt_XID_d;
         col_cnt_XID_q <= col_cnt_XID_d;
         filter_x_q    <= filter_x_d;
         filter_y_q    <= filter_y_d;
         ifmap_x_q     <= ifmap_x_d;
         ifmap_y_q     <= ifmap_y_d;
         ipsum_x_q     <= ipsum_x_d;
         ipsum_y_q     <= ipsum_y_d;
         opsum_x_q     <= opsum_x_d;
         opsum_y_q     <= opsum_y_d;
         x_done_q      <= x_done_d;
         y_done_q      <= y_done_d;
      end
   end

   assign filter_XID = filter_x_q;
   assign filter_YID = filter_y_q;
   assign ifmap_XID  = ifmap_x_q;
   assign ifmap_YID  = ifmap_y_q;
   assign ipsum_XID  = ipsum_x_q;
   assign ipsum_YID  = ipsum_y_q;
   assign opsum_XID  = opsum_x_q;
   assign opsum_YID  = opsum_y_q;
   assign x_done     = x_done_q;
   assign y_done     = y_done_q;

endmodule

// File: tb/tb_multi_id_generator_core.sv
module tb_multi_id_generator_core;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [2:0] PE_ARRAY_H;
   logic [3:0] PE_ARRAY_W;
   logic [1:0] KERNEL_H;
   logic [2:0] p, q, r, t;
   logic [2:0] t_H, t_W, e;
   logic       LINEAR;
   logic [4:0] filter_XID, ifmap_XID, ipsum_XID, opsum_XID;
   logic [2:0] filter_YID, ifmap_YID, ipsum_YID, opsum_YID;
   logic       x_done, y_done;

   int n_checks = 0;
   int n_fail   = 0;
   int xr, yr;

   always #5 clk = ~clk;

   multi_id_generator_core dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .PE_ARRAY_H(PE_ARRAY_H), .PE_ARRAY_W(PE_ARRAY_W), .KERNEL_H(KERNEL_H),
      .p(p), .q(q), .r(r), .t(t),
      .t_H(t_H), .t_W(t_W), .e(e), .LINEAR(LINEAR),
      .filter_XID(filter_XID), .filter_YID(filter_YID),
      .ifmap_XID(ifmap_XID), .ifmap_YID(ifmap_YID),
      .ipsum_XID(ipsum_XID), .ipsum_YID(ipsum_YID),
      .opsum_XID(opsum_XID), .opsum_YID(opsum_YID),
      .x_done(x_done), .y_done(y_done)
   );

   // All eight tags packed: filter X/Y, ifmap X/Y, ipsum X/Y, opsum X/Y.
   logic [31:0] ids;
   assign ids = {filter_XID, filter_YID, ifmap_XID, ifmap_YID,
                 ipsum_XID, ipsum_YID, opsum_XID, opsum_YID};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0;
      p = 3'd5; q = 3'd6; r = 3'd7; t = 3'd3;
      PE_ARRAY_H = 3'd6; PE_ARRAY_W = 4'd8; KERNEL_H = 2'd3;
      t_H = 3'd1; t_W = 3'd2; e = 3'd4; LINEAR = 1'b0;
      tick(); tick();
      check("reset_ids", ids, 32'd0);
      check("reset_flags", {x_done, y_done}, 2'b00);
      rst_n = 1'b1;
      tick(); tick();
      check("idle_hold", {ids, x_done, y_done}, 34'd0);

      // Conv scan 6x8. Edge n after the start edge loads PE index n-1.
      pulse_start();
      xr = -1; yr = -1;
      for (int n = 1; n <= 60 && xr < 0; n++) begin
         tick();
         if (y_done && yr < 0) yr = n;
         if (x_done) xr = n;
         // PE(1,5): sv=0 ri=1 sh=1 cj=1 span=6 -> ifmap X = 1+1+6 = 8
         if (n == 14) check("pe_1_5", ids, {5'd1, 3'd1, 5'd8, 3'd0, 5'd5, 3'd0, 5'd5, 3'd0});
         // PE(2,7): sv=0 ri=2 sh=1 cj=3 -> ifmap X = 2+3+6 = 11
         if (n == 24) check("pe_2_7", ids, {5'd1, 3'd2, 5'd11, 3'd0, 5'd7, 3'd0, 5'd7, 3'd0});
         // PE(4,0): sv=1 not < t_H -> inactive
         if (n == 33) check("pe_4_0_inactive", ids, {5'h1F, 3'h7, 5'h1F, 3'h7, 5'h1F, 3'h7, 5'h1F, 3'h7});
      end
      check("conv_y_done_edge", yr, 41);
      check("conv_x_done_edge", xr, 48);
      tick(); tick(); tick();
      check("done_hold", {x_done, y_done, ids},
            {2'b11, 5'h1F, 3'h7, 5'h1F, 3'h7, 5'h1F, 3'h7, 5'h1F, 3'h7});

      // Restart from DONE clears flags; then restart again at scan edge 10.
      pulse_start();
      check("start_clears_flags", {x_done, y_done}, 2'b00);
      for (int n = 1; n <= 9; n++) tick();
      check("pre_restart_pe_1_0_fy", filter_YID, 3'd1);
      pulse_start();
      tick();
      check("restart_pe_0_0", ids, 32'd0);
      xr = -1;
      for (int n = 2; n <= 60 && xr < 0; n++) begin
         tick();
         if (x_done) xr = n;
      end
      check("restart_x_done_edge", xr, 48);

      // Reset mid-scan: edge 20 loads PE(2,3) with filter Y = 2.
      pulse_start();
      for (int n = 1; n <= 20; n++) tick();
      check("pre_reset_pe_2_3", ids, {5'd0, 3'd2, 5'd5, 3'd0, 5'd3, 3'd0, 5'd3, 3'd0});
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("reset_mid_scan", {ids, x_done, y_done}, 34'd0);
      for (int n = 0; n < 10; n++) tick();
      check("post_reset_idle", {ids, x_done, y_done}, 34'd0);

      // Fully-connected mapping, 2x3 array.
      PE_ARRAY_H = 3'd2; PE_ARRAY_W = 4'd3; LINEAR = 1'b1;
      pulse_start();
      xr = -1; yr = -1;
      for (int n = 1; n <= 20 && xr < 0; n++) begin
         tick();
         if (y_done && yr < 0) yr = n;
         if (x_done) xr = n;
      end
      check("lin_x_done_edge", xr, 6);
      check("lin_y_done_edge", yr, 4);
      check("lin_pe_1_2", ids, {5'd2, 3'd1, 5'd0, 3'd1, 5'd2, 3'd1, 5'd2, 3'd1});

      // Empty array: immediate completion, tags untouched.
      PE_ARRAY_W = 4'd0;
      pulse_start();
      check("w0_flags", {x_done, y_done}, 2'b11);
      check("w0_ids_hold", ids, {5'd2, 3'd1, 5'd0, 3'd1, 5'd2, 3'd1, 5'd2, 3'd1});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
